// File: rtl/alu_core.sv
// alu_core: registered WIDTH-bit two's-complement ALU (ADD, SUB, AND, OR).
// The result has one cycle of latency, and out_valid marks each fresh result.
// Optional macro ALU_FLAGS_EN adds the registered status flags z/n/v/c.
module alu_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       ctrl,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_c
`endif
);

  localparam int unsigned SW = WIDTH + 1;

  logic [WIDTH-1:0] b_op;
  logic             cin;
  logic [WIDTH-1:0] result_c;
`ifdef ALU_FLAGS_EN
  logic [WIDTH:0]   sum_c;
  logic             v_c;
  logic             c_c;
`else
  logic [WIDTH-1:0] sum_c;
`endif

  // Operation stage. SUB is formed as A + ~B + 1 and shares the adder with ADD.
  always_comb begin
    b_op     = (ctrl == 2'b01) ? ~B : B;
    cin      = (ctrl == 2'b01);
`ifdef ALU_FLAGS_EN
    sum_c    = {1'b0, A} + {1'b0, b_op} + SW'(cin);
`else
    sum_c    = A + b_op + WIDTH'(cin);
`endif
    result_c = '0;
    case (ctrl)
      2'b00, 2'b01: result_c = sum_c[WIDTH-1:0];
      2'b10:        result_c = A & B;
      2'b11:        result_c = A | B;
      default:      result_c = '0;
    endcase
`ifdef ALU_FLAGS_EN
    v_c = 1'b0;
    c_c = 1'b0;
    if (!ctrl[1]) begin
      // Overflow: the adder operands agree in sign but the result sign differs.
      // For SUB the second operand is ~B, so this reduces to "A and B differ in sign".
      c_c = sum_c[WIDTH];
      v_c = (A[WIDTH-1] == b_op[WIDTH-1]) && (result_c[WIDTH-1] != A[WIDTH-1]);
    end
`endif
  end

  // Result register. Outputs hold their value while no beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      flag_c    <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out    <= result_c;
`ifdef ALU_FLAGS_EN
        flag_z <= (result_c == '0);
        flag_n <= result_c[WIDTH-1];
        flag_v <= v_c;
        flag_c <= c_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and exhaustive checks of alu_core against an
// integer-arithmetic reference model. The flag checks are compiled in with ALU_FLAGS_EN.
module tb_alu_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a_in;
  logic [3:0] b_in;
  logic [1:0] ctrl;
  logic [3:0] y;
  logic       y_valid;
`ifdef ALU_FLAGS_EN
  logic       fz, fn, fv, fc;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state: the values the outputs must show after each edge.
  logic [3:0] m_out;
  logic       m_valid;
  logic       m_z, m_n, m_v, m_c;

  always #5 clk = ~clk;

  alu_core #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (a_in),
    .B        (b_in),
    .ctrl     (ctrl),
    .out      (y),
    .out_valid(y_valid)
`ifdef ALU_FLAGS_EN
    ,
    .flag_z   (fz),
    .flag_n   (fn),
    .flag_v   (fv),
    .flag_c   (fc)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: signed and unsigned integer arithmetic taken straight from the operation rules.
  always @(posedge clk) begin
    int ua, ub, sa, sb, r;
    if (!rst_n) begin
      m_out = 4'd0; m_valid = 1'b0;
      m_z = 1'b0; m_n = 1'b0; m_v = 1'b0; m_c = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        ua = int'(a_in);
        ub = int'(b_in);
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        m_v = 1'b0;
        m_c = 1'b0;
        case (ctrl)
          2'd0: begin
            r = sa + sb;
            m_out = 4'(r & 15);
            m_v = (r > 7) || (r < -8);
            m_c = (ua + ub) > 15;
          end
          2'd1: begin
            r = sa - sb;
            m_out = 4'(r & 15);
            m_v = (r > 7) || (r < -8);
            m_c = (ua >= ub);
          end
          2'd2: m_out = 4'(ua & ub);
          default: m_out = 4'(ua | ub);
        endcase
        m_z = (m_out == 4'd0);
        m_n = (m_out >= 4'd8);
      end
    end
  end

  // Compare process: compare the DUT against the model on every falling edge once running.
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(y_valid), 32'(m_valid));
      check("out", 32'(y), 32'(m_out));
`ifdef ALU_FLAGS_EN
      check("flag_z", 32'(fz), 32'(m_z));
      check("flag_n", 32'(fn), 32'(m_n));
      check("flag_v", 32'(fv), 32'(m_v));
      check("flag_c", 32'(fc), 32'(m_c));
`endif
    end
  end

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] c);
    @(negedge clk);
    in_valid = v; a_in = a; b_in = b; ctrl = c;
  endtask

  // Wait for the capturing edge, then settle just after it.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [3:0] o, input logic v,
                     input logic z, input logic n, input logic ov, input logic c);
    check({name, "_out"}, 32'(y), 32'(o));
    check({name, "_valid"}, 32'(y_valid), 32'(v));
`ifdef ALU_FLAGS_EN
    check({name, "_z"}, 32'(fz), 32'(z));
    check({name, "_n"}, 32'(fn), 32'(n));
    check({name, "_v"}, 32'(fv), 32'(ov));
    check({name, "_c"}, 32'(fc), 32'(c));
`else
    if (z & n & ov & c) begin end
`endif
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; a_in = 4'b0101; b_in = 4'b0011; ctrl = 2'b00;
    // Reset held for two edges with a valid beat present.
    settle();
    chk_en = 1'b1;
    lit("rst1", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    lit("rst2", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 4'd0, 2'd0);
    rst_n = 1'b1;
    settle();

    // ADD
    drive(1'b1, 4'b0011, 4'b0100, 2'b00); settle();
    lit("add1", 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0111, 4'b0001, 2'b00); settle();
    lit("add2", 4'b1000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 4'b1111, 4'b0001, 2'b00); settle();
    lit("add3", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    // SUB
    drive(1'b1, 4'b1000, 4'b0001, 2'b01); settle();
    lit("sub1", 4'b0111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 4'b0010, 4'b0010, 2'b01); settle();
    lit("sub2", 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 4'b0001, 4'b0010, 2'b01); settle();
    lit("sub3", 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Logic operations on back-to-back cycles
    drive(1'b1, 4'b1100, 4'b1010, 2'b10); settle();
    lit("and", 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'b1100, 4'b1010, 2'b11); settle();
    lit("or", 4'b1110, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Hold and gap: one beat, then three idle cycles
    drive(1'b1, 4'b0010, 4'b0011, 2'b00); settle();
    lit("gap0", 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1111, 4'b1111, 2'b11); settle();
      lit("gap", 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    // Reset asserted mid-stream discards the in-flight beat
    drive(1'b1, 4'b0110, 4'b0001, 2'b00);
    rst_n = 1'b0;
    settle();
    lit("midrst", 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0001, 4'b0001, 2'b00);
    rst_n = 1'b1;
    settle();
    lit("postrst", 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Exhaustive sweep at full rate; the compare process checks every cycle.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 4; c++)
          drive(1'b1, 4'(a), 4'(b), 2'(c));
    drive(1'b0, 4'd0, 4'd0, 2'd0);
    repeat (3) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
